// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // FSM state encoding (plain constants for legacy-tool compatibility).
  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StReq   = 3'd1;
  localparam state_t StRecv  = 3'd2;
  localparam state_t StServe = 3'd3;
  localparam state_t StDrain = 3'd4;

  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned INSTS_PER_LINE = 16;

  // System bus read-request tag: {command, target space, transaction id}.
  localparam logic [3:0]  SYSBUS_READ   = 4'b0001;
  localparam logic        SYSBUS_MEMORY = 1'b1;
  localparam logic [12:0] READ_TAG      = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

endpackage

// File: rtl/fetch_unit_line_buffer.sv
// One cache-line buffer: written one bus beat at a time, read one 32-bit word at a time.
module line_buffer #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Beats     = 8,
  parameter int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1,
  parameter int unsigned Words     = Beats * DataWidth / 32,
  parameter int unsigned WordW     = $clog2(Words)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [BeatW-1:0]     beat_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [WordW-1:0]     word_i,
  output logic [31:0]          rdata_o
);

  logic [Beats*DataWidth-1:0] flat;
  logic [31:0]                words [Words];

  for (genvar b = 0; b < Beats; b++) begin : g_beat
    logic [DataWidth-1:0] data_q;

    // Capture the response beat addressed by beat_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_q <= '0;
      end else if (we_i && (beat_i == BeatW'(b))) begin
        data_q <= wdata_i;
      end
    end

    assign flat[b*DataWidth +: DataWidth] = data_q;
  end

  for (genvar w = 0; w < Words; w++) begin : g_word
    assign words[w] = flat[w*32 +: 32];
  end

  assign rdata_o = words[word_i];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests 64-byte lines over the system bus, buffers them and
// hands 32-bit instructions to decode with a valid/ready handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [63:0]               entry_pc,
  input  logic                      redirect,
  input  logic [63:0]               redirect_pc,
  output logic                      reqcyc,
  input  logic                      reqack,
  output logic [BUS_DATA_WIDTH-1:0] req,
  output logic [BUS_TAG_WIDTH-1:0]  reqtag,
  input  logic                      respcyc,
  output logic                      respack,
  input  logic [BUS_DATA_WIDTH-1:0] resp,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst,
  output logic [63:0]               inst_pc
);

  localparam int unsigned BeatW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int unsigned WordW = $clog2(LINE_BEATS * BUS_DATA_WIDTH / 32);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_BEATS - 1);
  localparam logic [3:0]       LastWord = 4'(INSTS_PER_LINE - 1);

  state_t            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              last_beat;

  // Beats are consumed in RECV (kept) and DRAIN (discarded); ignored elsewhere.
  assign respack    = respcyc && ((state_q == StRecv) || (state_q == StDrain));
  assign last_beat  = respack && (beat_q == LastBeat);

  assign reqcyc     = (state_q == StReq);
  assign req        = BUS_DATA_WIDTH'({pc_q[63:6], 6'b0});
  assign reqtag     = BUS_TAG_WIDTH'(READ_TAG);
  assign inst_valid = (state_q == StServe);
  assign inst_pc    = pc_q;

  line_buffer #(
    .DataWidth (BUS_DATA_WIDTH),
    .Beats     (LINE_BEATS)
  ) u_line_buffer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (respack && (state_q == StRecv)),
    .beat_i  (beat_q),
    .wdata_i (resp),
    .word_i  (pc_q[2 +: WordW]),
    .rdata_o (inst)
  );

  // Next-state logic: fetch sequencing, redirects and beat counting.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    beat_d  = beat_q;
    if (respack) begin
      beat_d = beat_q + 1'b1;
    end
    case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = entry_pc;
          state_d = StReq;
        end
      end
      StReq: begin
        beat_d = '0;
        if (redirect) begin
          pc_d = redirect_pc;
        end
        // A redirect racing the accept must still sink the whole response.
        if (reqack) begin
          state_d = redirect ? StDrain : StRecv;
        end
      end
      StRecv: begin
        if (last_beat) begin
          state_d = StServe;
        end
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = last_beat ? StReq : StDrain;
        end
      end
      StDrain: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (last_beat) begin
          state_d = StReq;
        end
      end
      StServe: begin
        // Redirect beats a simultaneous handshake; the buffered line is never reused.
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = StReq;
        end else if (inst_ready) begin
          pc_d = pc_q + 64'd4;
          if (pc_q[5:2] == LastWord) begin
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a scoreboard of expected instructions.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, redirect, reqack, respcyc, inst_ready;
  logic [63:0] entry_pc, redirect_pc, resp;
  logic        reqcyc, respack, inst_valid;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  fetch_unit #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .LINE_BEATS     (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .entry_pc    (entry_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .reqcyc      (reqcyc),
    .reqack      (reqack),
    .req         (req),
    .reqtag      (reqtag),
    .respcyc     (respcyc),
    .respack     (respack),
    .resp        (resp),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; redirect = 0; reqack = 0; respcyc = 0; inst_ready = 0;
    entry_pc = '0; redirect_pc = '0; resp = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    step();
    step();
    reset = 1;
    step();
    sb.delete();
  endtask

  // Accept the pending request, return a full line and queue the words decode should see.
  task automatic fetch_line(input logic [63:0] pc, input logic [63:0] seed, output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !reqcyc; i++) step();
    if (!reqcyc) return;
    reqack = 1;
    step();
    reqack = 0;
    for (int b = 0; b < 8; b++) begin
      respcyc = 1;
      resp    = seed + 64'(b);
      step();
    end
    respcyc = 0;
    for (int w = int'(pc[5:2]); w < 16; w++) begin
      logic [63:0] bv;
      exp_t e;
      bv     = seed + 64'(w / 2);
      e.inst = (w % 2 == 1) ? bv[63:32] : bv[31:0];
      e.pc   = {pc[63:6], 4'(w), 2'b00};
      sb.push_back(e);
    end
    ok = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset   = 0;
    respcyc = 1;
    #1;
    total++;
    if (reqcyc !== 1'b0 || inst_valid !== 1'b0 || respack !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got reqcyc=%b inst_valid=%b respack=%b want 0/0/0",
               reqcyc, inst_valid, respack);
    end
    total++;
    if (inst_pc !== 64'h0 || req !== 64'h0) begin
      bad++;
      $display("FAIL reset_pc got inst_pc=%h req=%h want 0/0", inst_pc, req);
    end
    respcyc = 0;
    step();
    reset = 1;
    step();
    step();
    total++;
    if (reqcyc !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got reqcyc=%b want 0", reqcyc);
    end
  endtask

  task automatic test_basic();
    bit   ok;
    exp_t e;
    do_reset();
    entry_pc = 64'h1000;
    start    = 1;
    step();
    start = 0;
    #1;
    total++;
    if (reqcyc !== 1'b1 || req !== 64'h1000 || reqtag !== READ_TAG) begin
      bad++;
      $display("FAIL basic_req got reqcyc=%b req=%h tag=%h want 1/1000/%h",
               reqcyc, req, reqtag, READ_TAG);
    end
    step();
    step();
    total++;
    if (reqcyc !== 1'b1 || req !== 64'h1000 || reqtag !== READ_TAG) begin
      bad++;
      $display("FAIL basic_req_hold got reqcyc=%b req=%h want 1/1000", reqcyc, req);
    end
    fetch_line(64'h1000, 64'h0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_fetch got no request want request"); end
    #1;
    total++;
    if (inst_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency got inst_valid=%b want 1", inst_valid);
    end
    inst_ready = 1;
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      total++;
      if (inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc) begin
        bad++;
        $display("FAIL basic_inst%0d got v=%b inst=%h pc=%h want 1/%h/%h",
                 i, inst_valid, inst, inst_pc, e.inst, e.pc);
      end
      step();
    end
    inst_ready = 0;
  endtask

  task automatic test_line_end();
    bit   ok;
    exp_t e;
    do_reset();
    entry_pc = 64'h103C;
    start    = 1;
    step();
    start = 0;
    fetch_line(64'h103C, 64'h1111_2222_3333_0000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL line_end_fetch got no request want request"); end
    inst_ready = 1;
    #1;
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc) begin
      bad++;
      $display("FAIL line_end_inst got v=%b inst=%h pc=%h want 1/%h/%h",
               inst_valid, inst, inst_pc, e.inst, e.pc);
    end
    step();
    inst_ready = 0;
    #1;
    total++;
    if (inst_valid !== 1'b0 || reqcyc !== 1'b1 || req !== 64'h1040) begin
      bad++;
      $display("FAIL line_end_next got v=%b reqcyc=%b req=%h want 0/1/1040",
               inst_valid, reqcyc, req);
    end
  endtask

  task automatic test_stall();
    bit   ok;
    exp_t e;
    do_reset();
    entry_pc = 64'h2010;
    start    = 1;
    step();
    start = 0;
    fetch_line(64'h2010, 64'hDEAD_BEEF_0000_0100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_fetch got no request want request"); end
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      // A start pulse outside IDLE must have no effect.
      start    = (i == 2);
      entry_pc = 64'h9000;
      #1;
      total++;
      if (inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc) begin
        bad++;
        $display("FAIL stall_hold%0d got v=%b inst=%h pc=%h want 1/%h/%h",
                 i, inst_valid, inst, inst_pc, e.inst, e.pc);
      end
      step();
    end
    start      = 0;
    inst_ready = 1;
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      total++;
      if (inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc) begin
        bad++;
        $display("FAIL stall_resume%0d got v=%b inst=%h pc=%h want 1/%h/%h",
                 i, inst_valid, inst, inst_pc, e.inst, e.pc);
      end
      step();
    end
    inst_ready = 0;
  endtask

  task automatic test_redirect_recv();
    do_reset();
    entry_pc = 64'h1000;
    start    = 1;
    step();
    start  = 0;
    reqack = 1;
    step();
    reqack = 0;
    for (int b = 0; b < 3; b++) begin
      respcyc = 1;
      resp    = 64'(b);
      step();
    end
    respcyc     = 0;
    redirect    = 1;
    redirect_pc = 64'h2000;
    step();
    redirect = 0;
    for (int b = 0; b < 5; b++) begin
      respcyc = 1;
      resp    = 64'hFFFF_0000 + 64'(b);
      #1;
      total++;
      if (respack !== 1'b1 || inst_valid !== 1'b0 || reqcyc !== 1'b0) begin
        bad++;
        $display("FAIL drain_beat%0d got ack=%b v=%b reqcyc=%b want 1/0/0",
                 b, respack, inst_valid, reqcyc);
      end
      step();
    end
    respcyc = 1;
    #1;
    total++;
    if (inst_valid !== 1'b0 || reqcyc !== 1'b1 || req !== 64'h2000 || respack !== 1'b0) begin
      bad++;
      $display("FAIL drain_done got v=%b reqcyc=%b req=%h ack=%b want 0/1/2000/0",
               inst_valid, reqcyc, req, respack);
    end
    respcyc = 0;
  endtask

  task automatic test_redirect_req();
    bit   ok;
    exp_t e;
    do_reset();
    entry_pc = 64'h1000;
    start    = 1;
    step();
    start       = 0;
    redirect    = 1;
    redirect_pc = 64'h5040;
    step();
    redirect = 0;
    #1;
    total++;
    if (reqcyc !== 1'b1 || req !== 64'h5040) begin
      bad++;
      $display("FAIL redir_req got reqcyc=%b req=%h want 1/5040", reqcyc, req);
    end
    fetch_line(64'h5040, 64'h0123_4567_89AB_CDEF, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL redir_req_fetch got no request want request"); end
    inst_ready = 1;
    #1;
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc) begin
      bad++;
      $display("FAIL redir_req_inst got v=%b inst=%h pc=%h want 1/%h/%h",
               inst_valid, inst, inst_pc, e.inst, e.pc);
    end
    step();
    inst_ready = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    entry_pc = 64'h1000;
    start    = 1;
    step();
    start  = 0;
    reqack = 1;
    step();
    reqack = 0;
    for (int b = 0; b < 4; b++) begin
      respcyc = 1;
      resp    = 64'(b);
      step();
    end
    resp = 64'h4;
    #2;
    reset = 0;
    #1;
    total++;
    if (reqcyc !== 1'b0 || inst_valid !== 1'b0 || respack !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got reqcyc=%b v=%b ack=%b want 0/0/0",
               reqcyc, inst_valid, respack);
    end
    step();
    step();
    reset       = 1;
    redirect    = 1;
    redirect_pc = 64'h4000;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (reqcyc !== 1'b0 || respack !== 1'b0 || inst_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet%0d got reqcyc=%b ack=%b v=%b want 0/0/0",
                 i, reqcyc, respack, inst_valid);
      end
    end
    clear_inputs();
    entry_pc = 64'h1000;
    start    = 1;
    step();
    start = 0;
    #1;
    total++;
    if (reqcyc !== 1'b1 || req !== 64'h1000) begin
      bad++;
      $display("FAIL restart got reqcyc=%b req=%h want 1/1000", reqcyc, req);
    end
  endtask

  task automatic test_redirect_serve();
    bit   ok;
    exp_t e;
    do_reset();
    entry_pc = 64'h1000;
    start    = 1;
    step();
    start = 0;
    fetch_line(64'h1000, 64'h5555_0000_AAAA_0000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL redir_serve_fetch got no request want request"); end
    inst_ready  = 1;
    redirect    = 1;
    redirect_pc = 64'h3000;
    step();
    inst_ready = 0;
    redirect   = 0;
    sb.delete();
    #1;
    total++;
    if (inst_valid !== 1'b0 || reqcyc !== 1'b1 || req !== 64'h3000) begin
      bad++;
      $display("FAIL redir_serve got v=%b reqcyc=%b req=%h want 0/1/3000",
               inst_valid, reqcyc, req);
    end
    fetch_line(64'h3000, 64'h7777_8888_9999_0000, ok);
    inst_ready = 1;
    #1;
    e = sb.pop_front();
    total++;
    if (!ok || inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc) begin
      bad++;
      $display("FAIL redir_serve_inst got v=%b inst=%h pc=%h want 1/%h/%h",
               inst_valid, inst, inst_pc, e.inst, e.pc);
    end
    step();
    inst_ready = 0;
  endtask

  task automatic test_wrap();
    bit   ok;
    exp_t e;
    do_reset();
    entry_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    start    = 1;
    step();
    start = 0;
    fetch_line(64'hFFFF_FFFF_FFFF_FFFC, 64'hCAFE_F00D_0000_0000, ok);
    inst_ready = 1;
    #1;
    e = sb.pop_front();
    total++;
    if (!ok || inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc) begin
      bad++;
      $display("FAIL wrap_inst got v=%b inst=%h pc=%h want 1/%h/%h",
               inst_valid, inst, inst_pc, e.inst, e.pc);
    end
    step();
    inst_ready = 0;
    #1;
    total++;
    if (reqcyc !== 1'b1 || req !== 64'h0) begin
      bad++;
      $display("FAIL wrap_req got reqcyc=%b req=%h want 1/0", reqcyc, req);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_line_end();
    test_stall();
    test_redirect_recv();
    test_redirect_req();
    test_reset_mid();
    test_redirect_serve();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus beat width.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, bus tag width.
REQ-003 SHALL have parameter LINE_BEATS, default 8, beats per 512-bit line.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, asynchronous reset, asserted when 0.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins fetching at entry_pc.
REQ-008 SHALL have port entry_pc, input, 64, first fetch address, 4-byte aligned.
REQ-009 SHALL have port redirect, input, 1, pulse that replaces the fetch PC.
REQ-010 SHALL have port redirect_pc, input, 64, new fetch address.
REQ-011 SHALL have port reqcyc, output, 1, bus request valid (arbiter channel 0).
REQ-012 SHALL have port reqack, input, 1, request accepted.
REQ-013 SHALL have port req, output, BUS_DATA_WIDTH, line address.
REQ-014 SHALL have port reqtag, output, BUS_TAG_WIDTH, request tag.
REQ-015 SHALL have port respcyc, input, 1, response beat valid.
REQ-016 SHALL have port respack, output, 1, response beat consumed.
REQ-017 SHALL have port resp, input, BUS_DATA_WIDTH, response beat data.
REQ-018 SHALL have port inst_valid, output, 1, instruction valid to decode.
REQ-019 SHALL have port inst_ready, input, 1, decode accepts instruction.
REQ-020 SHALL have port inst, output, 32, instruction word.
REQ-021 SHALL have port inst_pc, output, 64, address of inst.

Function
REQ-022 SHALL implement states IDLE, REQ, RECV, SERVE, DRAIN.
- IDLE: start -> pc=entry_pc, go REQ.
- REQ: reqcyc=1, req={pc[63:6],6'b0}, reqtag={`SYSBUS_READ,`SYSBUS_MEMORY,8'h00}. Hold req, reqtag and reqcyc stable until reqack. On reqack go RECV with beat=0.
- RECV: respack=respcyc (same cycle). Each accepted beat writes line[64*beat+:64]=resp, beat++. Accepting beat LINE_BEATS-1 goes SERVE.
- SERVE: inst_valid=1, inst=line[32*pc[5:2]+:32], inst_pc=pc. On inst_valid&inst_ready: pc+=4. If pc[5:2]==15, go REQ with the next line. Otherwise stay in SERVE.
REQ-023 Handshake transfer: a transfer SHALL occur only on a cycle where inst_valid&inst_ready. Transfer latency SHALL be 0 cycles. inst and inst_pc SHALL stay stable while inst_valid&!inst_ready.
REQ-024 Minimum latency SHALL be start -> reqcyc on the next cycle. The last beat accepted -> inst_valid on the next cycle.
REQ-025 Redirect in IDLE SHALL be ignored.
REQ-026 Redirect in SERVE SHALL set pc=redirect_pc, drop inst_valid the next cycle, and go REQ. This applies even if the current line holds redirect_pc; no line-hit reuse.
REQ-027 Redirect in REQ before reqack SHALL update pc and req on the next cycle while keeping reqcyc=1.
REQ-028 Redirect in REQ on the same cycle as reqack SHALL go DRAIN with pc=redirect_pc.
REQ-029 Redirect in RECV SHALL go DRAIN with pc=redirect_pc. The bus transaction cannot be aborted.
REQ-030 DRAIN SHALL ack and discard the remaining beats, then go REQ. The line contents are don't-care.
REQ-031 Redirect together with inst_ready in SERVE: the redirect SHALL win, and pc SHALL become redirect_pc, not pc+4.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 pc SHALL wrap modulo 2^64.
REQ-034 respcyc outside RECV/DRAIN SHALL be ignored, with respack=0.
REQ-035 inst_valid SHALL be 0 in every state except SERVE.
REQ-036 reqcyc SHALL be 1 only in REQ.

Reset
REQ-037 On reset=0, the block SHALL asynchronously set state=IDLE, pc=0, beat=0, line=0, reqcyc=0, respack=0, inst_valid=0.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction. After release the block SHALL wait in IDLE for start.
REQ-039 All outputs SHALL be driven from registered state or from inputs gated by state, with no latches.

Structure
REQ-040 Package fetch_pkg SHALL hold the state enum, LINE_BYTES=64, INSTS_PER_LINE=16, and the read-tag constant.
REQ-041 Sub-module line_buffer SHALL hold the beat-indexed write and the word-indexed read.

Verification
REQ-042 start, entry_pc=0x1000; reqack after 2 cycles; 8 beats 0x0..0x7 -> req=0x1000, first inst=0x00000000 at inst_pc=0x1000, second inst=0x00000000 at 0x1004, third inst=0x00000001 at 0x1008.
REQ-043 entry_pc=0x103C, inst_ready=1 -> one inst at 0x103C, then reqcyc with req=0x1040.
REQ-044 inst_ready=0 for 5 cycles in SERVE -> inst and inst_pc are unchanged, and pc is not advanced.
REQ-045 redirect_pc=0x2000 after the 3rd beat of RECV -> 5 more beats are acked and no inst_valid is raised, then req=0x2000.
REQ-046 Reset low during beat 4 -> reqcyc=0, inst_valid=0 immediately. After release, no bus activity until start.
REQ-047 redirect and inst_ready in the same SERVE cycle, redirect_pc=0x3000 -> the next request address is 0x3000.
